// File: rtl/bus_select_ctrl_if.sv
// Handshake/data bundle between a transfer requester and bus_select_ctrl (out_parity only with BUS_SELECT_CTRL_PARITY_EN).
// Latency: none, wiring only.
// Backpressure: carries per-channel in_valid/in_ready and the out_valid/out_ready pair.
interface bus_select_ctrl_if #(
    parameter int WIDTH = 17,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
);
    localparam int SEL_W = $clog2(NCH);

    logic                 start;
    logic [SEL_W-1:0]     sel;
    logic [CNT_W-1:0]     len;
    logic                 abort;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef BUS_SELECT_CTRL_PARITY_EN
    logic                 out_parity;

    modport master (
        output start, sel, len, abort, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, done, err, out_parity
    );
    modport slave (
        input  start, sel, len, abort, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, done, err, out_parity
    );
`else
    modport master (
        output start, sel, len, abort, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, done, err
    );
    modport slave (
        input  start, sel, len, abort, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, done, err
    );
`endif
endinterface

// File: rtl/bus_select_ctrl.sv
// Moves len beats from one selected source channel to a registered output; optional out_parity via BUS_SELECT_CTRL_PARITY_EN.
// Latency: 1 cycle from input handshake to out_valid; done/err pulse one cycle after the deciding event.
// Backpressure: in_ready of the selected channel drops while the output register is full and out_ready is low.
module bus_select_ctrl #(
    parameter int WIDTH = 17,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    bus_select_ctrl_if.slave bus
);
    localparam int SEL_W = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               aborted_q;
    logic [WIDTH-1:0]   data_q;
    logic               valid_q;
    logic               done_q, err_q;
    logic               done_d, err_d;
    logic               load, set_abort;
    logic               sel_ok, out_free, xfer_rdy, accept;
    logic [NCH-1:0]     rdy;
    logic [WIDTH-1:0]   sel_data;

    assign sel_ok   = ({1'b0, bus.sel} < (SEL_W+1)'(NCH));
    assign out_free = !valid_q || bus.out_ready;
    // abort gates acceptance combinationally so no beat slips in on the abort cycle
    assign xfer_rdy = (state_q == XFER) && out_free && !bus.abort;
    assign sel_data = bus.in_data[int'(sel_q)*WIDTH +: WIDTH];

    always_comb begin
        rdy = '0;
        for (int k = 0; k < NCH; k++) begin
            rdy[k] = xfer_rdy && (sel_q == SEL_W'(k));
        end
    end

    assign accept = |(bus.in_valid & rdy);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        set_abort = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else if (bus.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                if (bus.abort) begin
                    set_abort = 1'b1;
                    state_d   = DRAIN;
                end else if (accept && (cnt_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = aborted_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                sel_q     <= bus.sel;
                cnt_q     <= bus.len;
                aborted_q <= 1'b0;
            end else if (accept) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (set_abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    // Output register: loads on accept, otherwise holds until the beat is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            data_q  <= sel_data;
            valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef BUS_SELECT_CTRL_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^sel_data;
        end
    end

    assign bus.out_parity = parity_q;
`endif

    assign bus.in_ready  = rdy;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
